// File: rtl/ov7670_gray_packer.sv
// ov7670_gray_packer: RGB565 -> 8-bit luma, four luma bytes packed per 32-bit
// AXI-Stream word, frame boundaries carried by tlast.
// Optional frame statistics are compiled in when GRAY_PACK_STATS_EN is defined;
// otherwise frame_count, err_count and frame_err are tied to 0.
module ov7670_gray_packer #(
    parameter int FRAME_PIXELS = 76800
) (
    input  logic        axis_aclk,
    input  logic        axis_areset,
    input  logic [15:0] s00_axis_tdata,
    input  logic        s00_axis_tvalid,
    input  logic        s00_axis_tlast,
    output logic        s00_axis_tready,
    output logic [31:0] m00_axis_tdata,
    output logic [3:0]  m00_axis_tkeep,
    output logic        m00_axis_tvalid,
    output logic        m00_axis_tlast,
    input  logic        m00_axis_tready,
    output logic [15:0] frame_count,
    output logic [15:0] err_count,
    output logic        frame_err
);

    // The whole pipeline advances together whenever the output register can
    // accept a new word; this doubles as the upstream ready.
    logic en;
    assign en              = !m00_axis_tvalid || m00_axis_tready;
    assign s00_axis_tready = en;

    // Stage 1 combinational: expand channels to 8 bits and weight them.
    logic [7:0]  r8, g8, b8;
    logic [15:0] luma_sum;
    logic [7:0]  y_next;
    assign r8       = {s00_axis_tdata[15:11], s00_axis_tdata[15:13]};
    assign g8       = {s00_axis_tdata[10:5],  s00_axis_tdata[10:9]};
    assign b8       = {s00_axis_tdata[4:0],   s00_axis_tdata[4:2]};
    // Weights sum to 256, so the worst case is 256*255 = 65280: fits 16 bits.
    assign luma_sum = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);
    assign y_next   = luma_sum[15:8];

    logic       valid1;
    logic       last1;
    logic [7:0] y1;

    // Stage 1 register: luma byte with its valid and frame-end flag.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            valid1 <= 1'b0;
            last1  <= 1'b0;
            y1     <= 8'h00;
        end else if (en) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of the others.
            valid1 <= s00_axis_tvalid;
            last1  <= s00_axis_tvalid && s00_axis_tlast;
            y1     <= y_next;
        end
    end

    // Stage 2 state: lane index and bytes 0..2 of the word being built.
    logic [1:0]  idx;
    logic [23:0] acc;
    logic        word_complete;
    logic [31:0] pack_data;
    logic [3:0]  pack_keep;

    assign word_complete = valid1 && ((idx == 2'd3) || last1);

    // Assemble the outgoing word: held bytes below idx, current byte at idx,
    // zeros above. Stale accumulator bytes above idx are masked here, so the
    // accumulator never needs clearing between words.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        pack_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < idx) pack_data[8*i +: 8] = acc[8*i +: 8];
        end
        pack_data[{idx, 3'b000} +: 8] = y1;
        pack_keep = 4'b1111 >> (2'd3 - idx);
    end

    // Stage 2 register: byte packing and the output word register.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            idx             <= 2'd0;
            acc             <= 24'h0;
            m00_axis_tdata  <= 32'h0;
            m00_axis_tkeep  <= 4'h0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tvalid <= 1'b0;
        end else if (en) begin
            // en high means the held word (if any) is being consumed now, so
            // tvalid simply follows whether a new word is loaded.
            m00_axis_tvalid <= word_complete;
            if (word_complete) begin
                m00_axis_tdata <= pack_data;
                m00_axis_tkeep <= pack_keep;
                m00_axis_tlast <= last1;
                idx            <= 2'd0;
            end else if (valid1) begin
                acc[{idx, 3'b000} +: 8] <= y1;
                idx                     <= idx + 2'd1;
            end
        end
    end

`ifdef GRAY_PACK_STATS_EN
    logic [16:0] pix_cnt;
    logic [17:0] pix_cnt_inc;
    logic        accept;
    logic        length_ok;

    assign accept      = s00_axis_tvalid && en;
    assign pix_cnt_inc = {1'b0, pix_cnt} + 18'd1;
    // A saturated counter yields 2^17 here, which can never match.
    assign length_ok   = (pix_cnt_inc == 18'(FRAME_PIXELS));

    // Frame length check on the input handshake, independent of output stalls.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            pix_cnt     <= 17'h0;
            frame_count <= 16'h0;
            err_count   <= 16'h0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (accept) begin
                if (s00_axis_tlast) begin
                    pix_cnt     <= 17'h0;
                    frame_count <= frame_count + 16'd1;
                    if (!length_ok) begin
                        frame_err <= 1'b1;
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    end
                end else if (pix_cnt != 17'h1FFFF) begin
                    pix_cnt <= pix_cnt + 17'd1;
                end
            end
        end
    end
`else
    assign frame_count = 16'h0;
    assign err_count   = 16'h0;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_gray_packer.sv
// Self-checking bench for ov7670_gray_packer. A queue-based reference model
// turns the driven pixels into expected luma words; a monitor collects the
// words actually handed off and checks stall stability and ready behaviour.
// Frame statistics are checked when GRAY_PACK_STATS_EN is defined and are
// required to stay 0 otherwise.
module tb_ov7670_gray_packer;
    localparam int FP = 640;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_tdata = 16'h0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] frame_count;
    logic [15:0] err_count;
    logic        frame_err;

    ov7670_gray_packer #(.FRAME_PIXELS(FP)) dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tkeep  (m_tkeep),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready),
        .frame_count     (frame_count),
        .err_count       (err_count),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int unsigned ready_pct = 100;

    word_t       exp_q[$];
    word_t       got_q[$];
    logic [15:0] pix_q[$];
    logic [7:0]  pend_q[$];
    int          frame_len   = 0;
    int          exp_frames  = 0;
    int          exp_errs    = 0;
    int          last_pc     = 0;
    int          rise_cyc    = -1;
    int          err_pulses  = 0;
    int          err_cyc     = -1;
    logic        prev_stall  = 1'b0;
    logic        prev_valid  = 1'b0;
    word_t       prev_word;
    word_t       cur;

    assign cur = {m_tdata, m_tkeep, m_tlast};

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        m_tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
    end

    // Reference luma: scale each channel to 8 bits, weighted sum / 256.
    function automatic logic [7:0] luma(input logic [15:0] p);
        int r5 = int'(p[15:11]);
        int g6 = int'(p[10:5]);
        int b5 = int'(p[4:0]);
        int r8 = r5 * 8 + r5 / 4;
        int g8 = g6 * 4 + g6 / 16;
        int b8 = b5 * 8 + b5 / 4;
        return 8'((77 * r8 + 150 * g8 + 29 * b8) / 256);
    endfunction

    // Emit the pending model bytes as one expected word.
    task automatic model_flush(input logic lst);
        word_t w;
        w.data = 32'h0;
        foreach (pend_q[i]) w.data[8*i +: 8] = pend_q[i];
        w.keep = 4'((1 << pend_q.size()) - 1);
        w.last = lst;
        exp_q.push_back(w);
        pend_q.delete();
    endtask

    // Monitor: sample away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (s_tready !== (!m_tvalid || m_tready)) begin
                bad++;
                $display("FAIL s_tready_rule: got %b want %b at cyc %0d",
                         s_tready, !m_tvalid || m_tready, cyc);
            end
            if (prev_stall) begin
                total++;
                if (!m_tvalid || cur !== prev_word) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h at cyc %0d",
                             m_tvalid, cur, prev_word, cyc);
                end
            end
            if (m_tvalid && !prev_valid) rise_cyc = cyc;
            if (m_tvalid && m_tready) got_q.push_back(cur);
            if (frame_err) begin
                err_pulses++;
                err_cyc = cyc;
            end
`ifndef GRAY_PACK_STATS_EN
            total++;
            if (frame_count !== 16'h0 || err_count !== 16'h0 || frame_err !== 1'b0) begin
                bad++;
                $display("FAIL stats_tied_off: got fc=%h ec=%h fe=%b want 0", frame_count, err_count, frame_err);
            end
`endif
            prev_stall = m_tvalid && !m_tready;
            prev_valid = m_tvalid;
            prev_word  = cur;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    // Drive every pixel in pix_q; tlast on the final one when last_flag is set.
    // Entered and left just after a rising edge.
    task automatic send_pixels(input logic last_flag);
        logic [15:0] px;
        logic        lst;
        int          n;
        while (pix_q.size() > 0) begin
            px       = pix_q.pop_front();
            lst      = last_flag && (pix_q.size() == 0);
            s_tdata  = px;
            s_tvalid = 1'b1;
            s_tlast  = lst;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_tready && n < 1000);
            if (!s_tready) begin
                total++;
                bad++;
                $display("FAIL input_timeout: got s_tready=0 want 1 within 1000 cycles");
            end
            last_pc = cyc;
            @(posedge clk);
            #1;
            pend_q.push_back(luma(px));
            frame_len++;
            if (pend_q.size() == 4 || lst) model_flush(lst);
            if (lst) begin
                exp_frames++;
                if (frame_len != FP) exp_errs++;
                frame_len = 0;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Wait (bounded) for the output side to deliver everything expected.
    task automatic drain();
        int n = 0;
        while ((got_q.size() < exp_q.size() || m_tvalid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pix_q.delete();
        pend_q.delete();
        exp_q.delete();
        got_q.delete();
        frame_len  = 0;
        exp_frames = 0;
        exp_errs   = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_s_tready: got %b want 1", s_tready);
        end
        total++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== 38'h0) begin
            bad++;
            $display("FAIL reset_stream: got v=%b d=%h k=%h l=%b want all 0", m_tvalid, m_tdata, m_tkeep, m_tlast);
        end
        total++;
        if ({frame_count, err_count, frame_err} !== 33'h0) begin
            bad++;
            $display("FAIL reset_stats: got fc=%h ec=%h fe=%b want 0", frame_count, err_count, frame_err);
        end
        apply_reset();
    endtask

    task automatic test_single_word();
        int pc;
        ready_pct = 100;
        pix_q = '{16'hFFFF, 16'h0000, 16'hF800, 16'h001F};
        send_pixels(1'b1);
        pc = last_pc;
        drain();
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (rise_cyc != pc + 2) begin
            bad++;
            $display("FAIL single_latency: got %0d want %0d", rise_cyc - pc, 2);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_partial_word();
        ready_pct = 100;
        for (int i = 0; i < 6; i++) pix_q.push_back(16'h07E0);
        send_pixels(1'b1);
        drain();
        total++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            bad++;
            $display("FAIL partial_count: got %0d want 2", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL partial_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        ready_pct = 100;
        for (int f = 0; f < 8; f++) begin
            int len = int'($urandom_range(13, 1));
            for (int i = 0; i < len; i++) pix_q.push_back(16'($urandom));
            send_pixels(1'b1);
        end
        drain();
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
`ifdef GRAY_PACK_STATS_EN
        total++;
        if (frame_count !== 16'(exp_frames) || err_count !== 16'(exp_errs)) begin
            bad++;
            $display("FAIL b2b_stats: got fc=%0d ec=%0d want fc=%0d ec=%0d", frame_count, err_count, exp_frames, exp_errs);
        end
`endif
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        ready_pct = 30;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FP; i++) pix_q.push_back(16'($urandom));
            send_pixels(1'b1);
        end
        drain();
        total++;
        if (got_q.size() != FP / 2) begin
            bad++;
            $display("FAIL bp_count: got %0d want %0d", got_q.size(), FP / 2);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
        ready_pct = 100;
    endtask

    task automatic test_length_check();
        int pulses0;
        int pc;
        apply_reset();
        ready_pct = 50;
        for (int i = 0; i < FP; i++) pix_q.push_back(16'($urandom));
        send_pixels(1'b1);
        drain();
`ifdef GRAY_PACK_STATS_EN
        total++;
        if (frame_count !== 16'd1 || err_count !== 16'd0) begin
            bad++;
            $display("FAIL len_good: got fc=%0d ec=%0d want fc=1 ec=0", frame_count, err_count);
        end
`endif
        pulses0 = err_pulses;
        for (int i = 0; i < 100; i++) pix_q.push_back(16'($urandom));
        send_pixels(1'b1);
        pc = last_pc;
        drain();
`ifdef GRAY_PACK_STATS_EN
        total++;
        if (err_pulses - pulses0 != 1 || err_cyc != pc + 1) begin
            bad++;
            $display("FAIL len_err_pulse: got %0d pulses at +%0d want 1 at +1", err_pulses - pulses0, err_cyc - pc);
        end
        total++;
        if (frame_count !== 16'(exp_frames) || err_count !== 16'(exp_errs) || exp_frames != 2 || exp_errs != 1) begin
            bad++;
            $display("FAIL len_bad: got fc=%0d ec=%0d want fc=2 ec=1", frame_count, err_count);
        end
`endif
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL len_stream_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL len_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
        ready_pct = 100;
    endtask

    task automatic test_reset_mid_word();
        ready_pct = 100;
        pix_q = '{16'h1234, 16'hABCD};
        send_pixels(1'b0);
        apply_reset();
        pix_q = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        send_pixels(1'b1);
        drain();
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            bad++;
            $display("FAIL rst_mid_count: got %0d want 1", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rst_mid_word: got %h want %h", got_q[i], exp_q[i]);
            end
        end
`ifdef GRAY_PACK_STATS_EN
        total++;
        if (frame_count !== 16'd1) begin
            bad++;
            $display("FAIL rst_mid_stats: got fc=%0d want 1", frame_count);
        end
`endif
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_partial_word();
        test_back_to_back();
        test_backpressure();
        test_length_check();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
